// File: rtl/demux_stream_pkg.sv
// Shared definitions for the 1-to-2 stream demultiplexer: default widths,
// the channel enumeration and the per-slot occupancy states.
package demux_stream_pkg;

    // Default payload and counter widths used by the top-level parameters.
    localparam int DEFAULT_DATA_W = 8;
    localparam int DEFAULT_CNT_W  = 16;

    // Number of output channels served by the demultiplexer.
    localparam int NUM_CH = 2;

    // Output channel identifier; its encoding doubles as the in_sel value.
    typedef enum logic {
        CH0 = 1'b0,
        CH1 = 1'b1
    } ch_e;

    // Occupancy of a single-entry output slot.
    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    // Returns the other channel; used to advance the round-robin pointer.
    function automatic ch_e other_ch(input ch_e c);
        return (c == CH0) ? CH1 : CH0;
    endfunction

    // Converts a raw select bit into a channel identifier.
    function automatic ch_e ch_from_bit(input logic b);
        return b ? CH1 : CH0;
    endfunction

endpackage : demux_stream_pkg

// File: rtl/demux_stream_1x2_slot.sv
// Single-entry output slot: one payload register with valid/ready handshake
// and a saturating count of beats delivered downstream.
// A write and a drain in the same cycle keep the slot FULL with the new
// payload, so a continuously ready consumer sees no bubble.
module demux_out_slot
    import demux_stream_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int CNT_W  = DEFAULT_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en_i,
    input  logic [DATA_W-1:0] wr_data_i,
    output logic              can_accept_o,
    output logic              out_valid_o,
    output logic [DATA_W-1:0] out_data_o,
    input  logic              out_ready_i,
    output logic [CNT_W-1:0]  cnt_o
);

    slot_state_e       state_q, state_d;
    logic [DATA_W-1:0] data_q,  data_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic              drain;

    // A beat leaves the slot whenever it is held and downstream takes it.
    assign drain = (state_q == SLOT_FULL) && out_ready_i;

    // The slot can take a new beat if empty, or if its current beat leaves
    // this cycle. This never looks at the upstream valid.
    assign can_accept_o = (state_q == SLOT_EMPTY) || out_ready_i;

    assign out_valid_o = (state_q == SLOT_FULL);
    assign out_data_o  = data_q;
    assign cnt_o       = cnt_q;

    // State, payload and counter registers; reset discards any held beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SLOT_EMPTY;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: fill on write, empty on drain without refill.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;

        case (state_q)
            SLOT_EMPTY: begin
                if (wr_en_i) begin
                    state_d = SLOT_FULL;
                    data_d  = wr_data_i;
                end
            end
            SLOT_FULL: begin
                if (wr_en_i) begin
                    // Simultaneous drain and refill, or the caller only
                    // writes when the slot can accept, so stay FULL.
                    data_d = wr_data_i;
                end else if (out_ready_i) begin
                    state_d = SLOT_EMPTY;
                end
            end
            default: begin
                state_d = SLOT_EMPTY;
            end
        endcase

        // Delivered-beat counter sticks at its maximum instead of wrapping.
        if (drain && !(&cnt_q)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

endmodule : demux_out_slot

// File: rtl/demux_stream_1x2.sv
// 1-to-2 stream demultiplexer. Each upstream beat is routed into one of two
// single-entry output slots, selected by in_sel. Each slot counts the beats
// it delivers downstream.
// Optional feature, enabled by defining DEMUX_STREAM_RR_EN: adds input rr_en;
// while rr_en is high the destination comes from a 1-bit round-robin pointer
// (starting at channel 0, toggling on every accepted beat) and in_sel is
// ignored. Without the macro the pointer and the rr_en port do not exist.
module demux_stream_1x2
    import demux_stream_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int CNT_W  = DEFAULT_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
`ifdef DEMUX_STREAM_RR_EN
    input  logic              rr_en,
`endif
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_sel,
    output logic              in_ready,
    output logic              out0_valid,
    output logic [DATA_W-1:0] out0_data,
    input  logic              out0_ready,
    output logic              out1_valid,
    output logic [DATA_W-1:0] out1_data,
    input  logic              out1_ready,
    output logic [CNT_W-1:0]  cnt0,
    output logic [CNT_W-1:0]  cnt1
);

    // Per-channel views of the two slots, indexed by channel number.
    logic [NUM_CH-1:0] slot_can_accept;
    logic [NUM_CH-1:0] slot_wr_en;
    logic [NUM_CH-1:0] slot_valid;
    logic [NUM_CH-1:0] slot_ready;
    logic [DATA_W-1:0] slot_data [NUM_CH];
    logic [CNT_W-1:0]  slot_cnt  [NUM_CH];

    ch_e  target;
    logic accept;

    assign slot_ready[0] = out0_ready;
    assign slot_ready[1] = out1_ready;

    assign out0_valid = slot_valid[0];
    assign out1_valid = slot_valid[1];
    assign out0_data  = slot_data[0];
    assign out1_data  = slot_data[1];
    assign cnt0       = slot_cnt[0];
    assign cnt1       = slot_cnt[1];

`ifdef DEMUX_STREAM_RR_EN
    ch_e ptr_q, ptr_d;

    // Round-robin pointer register; restarts at channel 0 on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= CH0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // Destination choice and pointer advance; a stalled beat holds the pointer.
    always_comb begin
        target = rr_en ? ptr_q : ch_from_bit(in_sel);
        ptr_d  = ptr_q;
        if (rr_en && accept) begin
            ptr_d = other_ch(ptr_q);
        end
    end
`else
    // Destination comes straight from the select input.
    always_comb begin
        target = ch_from_bit(in_sel);
    end
`endif

    // Ready depends only on the target slot, never on in_valid, and is held
    // low for the whole reset so no beat is taken while state is cleared.
    assign in_ready = !rst && slot_can_accept[target];
    assign accept   = in_valid && in_ready;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_slot
            // Only the addressed slot is written; the other drains freely.
            assign slot_wr_en[gi] = accept && (target == ch_e'(gi));

            demux_out_slot #(
                .DATA_W (DATA_W),
                .CNT_W  (CNT_W)
            ) u_slot (
                .clk          (clk),
                .rst          (rst),
                .wr_en_i      (slot_wr_en[gi]),
                .wr_data_i    (in_data),
                .can_accept_o (slot_can_accept[gi]),
                .out_valid_o  (slot_valid[gi]),
                .out_data_o   (slot_data[gi]),
                .out_ready_i  (slot_ready[gi]),
                .cnt_o        (slot_cnt[gi])
            );
        end
    endgenerate

endmodule : demux_stream_1x2

// File: tb/tb_demux_stream_1x2.sv
// Scoreboard bench for demux_stream_1x2. The stimulus process predicts
// acceptance from a queue-per-channel model (each queue holds at most one
// beat) and pushes accepted payloads; a separate monitor compares the DUT
// outputs against the queue heads and pops on each downstream transfer.
// Counters are built narrow (CNT_W=4) so saturation is reached quickly.
module tb_demux_stream_1x2;

    localparam int DW      = 8;
    localparam int CW      = 4;
    localparam int CNT_MAX = 15;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_sel = 1'b0;
    logic          in_ready;
    logic          out0_valid, out1_valid;
    logic [DW-1:0] out0_data, out1_data;
    logic          out0_ready = 1'b0;
    logic          out1_ready = 1'b0;
    logic [CW-1:0] cnt0, cnt1;
`ifdef DEMUX_STREAM_RR_EN
    logic          rr_en = 1'b0;
`endif

    demux_stream_1x2 #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
`ifdef DEMUX_STREAM_RR_EN
        .rr_en      (rr_en),
`endif
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_ready   (in_ready),
        .out0_valid (out0_valid),
        .out0_data  (out0_data),
        .out0_ready (out0_ready),
        .out1_valid (out1_valid),
        .out1_data  (out1_data),
        .out1_ready (out1_ready),
        .cnt0       (cnt0),
        .cnt1       (cnt1)
    );

    always #5 clk = ~clk;

    // Reference model state shared by stimulus and monitor.
    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];
    int            exp_cnt0 = 0;
    int            exp_cnt1 = 0;
    bit            ptr = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle of stimulus: drive at the falling edge, check in_ready
    // against the model, and record an accepted beat after the rising edge.
    task automatic cycle(input bit v, input bit sel, input logic [DW-1:0] d,
                         input bit r0, input bit r1, input bit do_rst, input bit rr);
        bit tgt;
        bit exp_rdy;
        bit acc;
        @(negedge clk);
        in_valid   = v;
        in_sel     = sel;
        in_data    = d;
        out0_ready = r0;
        out1_ready = r1;
`ifdef DEMUX_STREAM_RR_EN
        rr_en      = rr;
`endif
        if (do_rst) begin
            rst = 1'b1;
            q0.delete();
            q1.delete();
            exp_cnt0 = 0;
            exp_cnt1 = 0;
            ptr = 1'b0;
            #1;
            check("rst out0_valid", {31'b0, out0_valid}, 0);
            check("rst out1_valid", {31'b0, out1_valid}, 0);
            check("rst out0_data", {24'b0, out0_data}, 0);
            check("rst out1_data", {24'b0, out1_data}, 0);
            check("rst cnt0", {28'b0, cnt0}, 0);
            check("rst cnt1", {28'b0, cnt1}, 0);
            check("rst in_ready", {31'b0, in_ready}, 0);
            $display("txn rst");
        end else begin
            rst = 1'b0;
            #1;
`ifdef DEMUX_STREAM_RR_EN
            tgt = rr ? ptr : sel;
`else
            tgt = sel;
`endif
            exp_rdy = tgt ? ((q1.size() == 0) || r1) : ((q0.size() == 0) || r0);
            check("in_ready", {31'b0, in_ready}, {31'b0, exp_rdy});
            acc = v && exp_rdy;
            $display("txn v=%0d sel=%0d tgt=%0d d=%02h r0=%0d r1=%0d acc=%0d",
                     v, sel, tgt, d, r0, r1, acc);
            @(posedge clk);
            #1;
            if (acc) begin
                if (tgt) q1.push_back(d);
                else     q0.push_back(d);
`ifdef DEMUX_STREAM_RR_EN
                if (rr) ptr = ~ptr;
`endif
            end
        end
    endtask

    // Monitor: between edges the model queues hold exactly what the DUT
    // slots should hold; on a downstream transfer the head is consumed.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            check("out0_valid", {31'b0, out0_valid}, {31'b0, q0.size() != 0});
            check("out1_valid", {31'b0, out1_valid}, {31'b0, q1.size() != 0});
            check("cnt0", {28'b0, cnt0}, exp_cnt0);
            check("cnt1", {28'b0, cnt1}, exp_cnt1);
            if (q0.size() != 0) begin
                check("out0_data", {24'b0, out0_data}, {24'b0, q0[0]});
                if (out0_ready) begin
                    void'(q0.pop_front());
                    if (exp_cnt0 < CNT_MAX) exp_cnt0++;
                end
            end
            if (q1.size() != 0) begin
                check("out1_data", {24'b0, out1_data}, {24'b0, q1[0]});
                if (out1_ready) begin
                    void'(q1.pop_front());
                    if (exp_cnt1 < CNT_MAX) exp_cnt1++;
                end
            end
        end
    end

    initial begin
        // Reset state.
        cycle(0, 0, 8'h00, 0, 0, 1, 0);

        // Single beat to channel 1, drained immediately; cnt1 becomes 1.
        cycle(1, 1, 8'hA5, 0, 1, 0, 0);
        cycle(0, 0, 8'h00, 0, 1, 0, 0);
        cycle(0, 0, 8'h00, 0, 1, 0, 0);

        // Back-pressure on channel 0: first beat held, second refused.
        cycle(1, 0, 8'h11, 0, 0, 0, 0);
        cycle(1, 0, 8'h22, 0, 0, 0, 0);
        cycle(1, 0, 8'h22, 0, 0, 0, 0);
        cycle(0, 0, 8'h00, 0, 0, 0, 0);
        cycle(0, 0, 8'h00, 1, 0, 0, 0);
        cycle(0, 0, 8'h00, 0, 0, 0, 0);

        // Drain and refill in the same cycle on channel 0: no bubble.
        cycle(1, 0, 8'h44, 0, 0, 0, 0);
        cycle(1, 0, 8'h33, 1, 0, 0, 0);
        cycle(0, 0, 8'h00, 1, 0, 0, 0);

        // Reset while both slots are full.
        cycle(1, 0, 8'h55, 0, 0, 0, 0);
        cycle(1, 1, 8'h66, 0, 0, 0, 0);
        cycle(1, 0, 8'h77, 0, 0, 1, 0);

`ifdef DEMUX_STREAM_RR_EN
        // Round-robin: in_sel fixed at 1, beats alternate starting at CH0.
        for (int i = 1; i <= 4; i++) cycle(1, 1, i[7:0], 1, 1, 0, 1);
        cycle(0, 0, 8'h00, 1, 1, 0, 0);
`endif

        // Counter saturation: 20 beats through channel 0.
        cycle(0, 0, 8'h00, 0, 0, 1, 0);
        for (int i = 0; i < 20; i++) cycle(1, 0, 8'h80 + i[7:0], 1, 0, 0, 0);
        cycle(0, 0, 8'h00, 1, 0, 0, 0);
        cycle(0, 0, 8'h00, 0, 0, 0, 0);
        #3;
        check("cnt0 saturated", {28'b0, cnt0}, CNT_MAX);

        // Randomized traffic with occasional resets.
        cycle(0, 0, 8'h00, 0, 0, 1, 0);
        for (int i = 0; i < 2000; i++) begin
            cycle(($urandom % 4) != 0, $urandom % 2, 8'($urandom),
                  ($urandom % 10) < 7, ($urandom % 10) < 6,
                  ($urandom % 64) == 0, $urandom % 2);
        end
        cycle(0, 0, 8'h00, 1, 1, 0, 0);
        cycle(0, 0, 8'h00, 1, 1, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_demux_stream_1x2
